// File: rtl/rt_timer_pkg.sv
// Shared register-map offsets and control-bit positions for the rt_timer slice.
package rt_timer_pkg;

    localparam int CTRL_OFS  = 0;
    localparam int COUNT_OFS = 1;
    localparam int EN_BIT    = 0;
    localparam int CLR_BIT   = 1;

    function automatic int count_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/rt_timer_core.sv
// Counter, enable, clear priority and tap falling-edge pulse generation.
module rt_timer_core
    import rt_timer_pkg::*;
#(
    parameter int                  WIDTH = 8,
    parameter int                  NTAPS = 4,
    parameter logic [NTAPS*8-1:0]  TAPS  = {8'd7, 8'd6, 8'd4, 8'd2}
) (
    input  logic             rt_clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ctrl_write,
    input  logic             ctrl_en,
    input  logic             ctrl_clr,
    output logic [WIDTH-1:0] timer,
    output logic             en,
    output logic [NTAPS-1:0] irq,
    output logic             ovf
);

    logic [WIDTH-1:0] timer_inc;
    logic [WIDTH-1:0] fall;
    logic [NTAPS-1:0] tap_fall;
    logic             clr;
    logic             inc;

    assign timer_inc = timer + WIDTH'(1);
    assign fall      = timer & ~timer_inc;
    assign clr       = ctrl_write & ctrl_clr;
    // Clear wins over a coincident tick; en here is the value before any write this cycle.
    assign inc       = tick & en & ~clr;

    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
        localparam int TAP_BIT = int'(TAPS[8*i +: 8]);
        assign tap_fall[i] = fall[TAP_BIT];
    end

    always_ff @(posedge rt_clk) begin
        if (reset) begin
            timer <= '0;
            en    <= 1'b0;
            irq   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (clr) begin
                timer <= '0;
            end else if (inc) begin
                timer <= timer_inc;
            end
            irq <= inc ? tap_fall : '0;
            ovf <= inc & (timer_inc == '0);
            if (ctrl_write) begin
                en <= ctrl_en;
            end
        end
    end

endmodule

// File: rtl/rt_timer.sv
// Bus-mapped free-running timer: address decode, count-byte shadow and registered read path.
module rt_timer
    import rt_timer_pkg::*;
#(
    parameter int                  WIDTH     = 8,
    parameter logic [23:0]         BASE_ADDR = 24'h002040,
    parameter int                  NTAPS     = 4,
    parameter logic [NTAPS*8-1:0]  TAPS      = {8'd7, 8'd6, 8'd4, 8'd2}
) (
    input  logic             rt_clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             bus_write,
    input  logic             bus_read,
    input  logic [23:0]      bus_address_in,
    input  logic [7:0]       bus_data_in,
    output logic [7:0]       bus_data_out,
    output logic             bus_data_valid,
    output logic [WIDTH-1:0] timer,
    output logic [NTAPS-1:0] irq,
    output logic             ovf
);

    localparam int NB = count_bytes(WIDTH);

    logic [23:0] offset;
    logic        hit_ctrl;
    logic        hit_count;
    logic [1:0]  byte_sel;
    logic [31:0] timer_wide;
    logic [31:0] shadow;
    logic [7:0]  read_data;
    logic        en;
    logic        unused_data;

    assign offset     = bus_address_in - BASE_ADDR;
    assign hit_ctrl   = (offset == 24'(CTRL_OFS));
    assign hit_count  = (offset >= 24'(COUNT_OFS)) && (offset < 24'(COUNT_OFS + NB));
    assign byte_sel   = 2'(offset - 24'(COUNT_OFS));
    assign timer_wide = 32'(timer);
    assign unused_data = ^bus_data_in[7:2];

    rt_timer_core #(
        .WIDTH (WIDTH),
        .NTAPS (NTAPS),
        .TAPS  (TAPS)
    ) u_core (
        .rt_clk     (rt_clk),
        .reset      (reset),
        .tick       (tick),
        .ctrl_write (bus_write & hit_ctrl),
        .ctrl_en    (bus_data_in[EN_BIT]),
        .ctrl_clr   (bus_data_in[CLR_BIT]),
        .timer      (timer),
        .en         (en),
        .irq        (irq),
        .ovf        (ovf)
    );

    // Byte 0 is read live; upper bytes come from the shadow taken at the last byte-0 read.
    always_comb begin
        read_data = '0;
        if (hit_ctrl) begin
            read_data[EN_BIT] = en;
        end else if (byte_sel == 2'd0) begin
            read_data = timer_wide[7:0];
        end else begin
            read_data = shadow[8*byte_sel +: 8];
        end
    end

    always_ff @(posedge rt_clk) begin
        if (reset) begin
            bus_data_out   <= '0;
            bus_data_valid <= 1'b0;
            shadow         <= '0;
        end else begin
            bus_data_valid <= bus_read & (hit_ctrl | hit_count);
            bus_data_out   <= (bus_read && (hit_ctrl || hit_count)) ? read_data : 8'h00;
            if (bus_read && hit_count && byte_sel == 2'd0) begin
                shadow <= timer_wide;
            end
        end
    end

endmodule
